// File: rtl/points_packetizer.sv
// points_packetizer: snapshots the four point centroids and the group count on
// each VGA_VS falling edge. It then streams them as a 21-byte framed packet:
//   AA 55 seq cnt {H_hi H_lo V_hi V_lo} x4 checksum
// The packet goes out on a valid/ready byte interface toward the UART TX.
// The checksum is the 8-bit sum of bytes 2..19 and is accumulated per handshake.
// Optional build macro: POINTS_PACKETIZER_SKIP_EMPTY_EN. When it is defined,
// frames with cnt==0 are not sent.
module points_packetizer #(
   parameter logic [7:0] SYNC0      = 8'hAA,
   parameter logic [7:0] SYNC1      = 8'h55,
   parameter int         MAX_POINTS = 4
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        VGA_VS,
   input  logic [15:0] i_POINTS_H_0,
   input  logic [15:0] i_POINTS_H_1,
   input  logic [15:0] i_POINTS_H_2,
   input  logic [15:0] i_POINTS_H_3,
   input  logic [15:0] i_POINTS_V_0,
   input  logic [15:0] i_POINTS_V_1,
   input  logic [15:0] i_POINTS_V_2,
   input  logic [15:0] i_POINTS_V_3,
   input  logic [2:0]  i_POINT_COUNT,
   output logic [7:0]  o_TX_DATA,
   output logic        o_TX_VALID,
   input  logic        i_TX_READY,
   output logic        o_BUSY,
   output logic [7:0]  o_FRAME_CNT,
   output logic [7:0]  o_DROP_CNT
);

   // Index of the checksum byte; the point bytes end one before it.
   localparam logic [4:0] LAST_IDX = 5'(4 + 4 * MAX_POINTS);

   typedef enum logic {IDLE, SEND} state_t;

   state_t            state_q;
   logic              vs_d_q, fall_d_q;
   logic [3:0][15:0]  h_q, v_q;
   logic [2:0]        cnt_q;
   logic [7:0]        seq_q, csum_q;
   logic [4:0]        idx_q;
   logic [7:0]        tx_data_q;
   logic              tx_valid_q;
   logic [7:0]        frame_q, drop_q;

   logic              fall, xfer, start_ok;
   logic [2:0]        cnt_clamp;
   logic [4:0]        idx_d, slot;
   logic [7:0]        csum_d, byte_d, pt_byte;
   logic [15:0]       word;

   assign fall      = vs_d_q & ~VGA_VS;
   assign xfer      = tx_valid_q & i_TX_READY;
   assign cnt_clamp = (i_POINT_COUNT > 3'd4) ? 3'd4 : i_POINT_COUNT;
   assign idx_d     = idx_q + 5'd1;
   // Only bytes seq..last point byte feed the checksum.
   assign csum_d    = csum_q + (((idx_q >= 5'd2) && (idx_q < LAST_IDX)) ? tx_data_q : 8'd0);

`ifdef POINTS_PACKETIZER_SKIP_EMPTY_EN
   assign start_ok = (cnt_clamp != 3'd0);
`else
   assign start_ok = 1'b1;
`endif

   assign o_TX_DATA   = tx_data_q;
   assign o_TX_VALID  = tx_valid_q;
   assign o_BUSY      = (state_q != IDLE);
   assign o_FRAME_CNT = frame_q;
   assign o_DROP_CNT  = drop_q;

   // Select the byte that follows the current one. The checksum byte uses the
   // sum that already includes the byte being handed off now.
   always_comb begin
      slot    = idx_d - 5'd4;
      word    = slot[1] ? v_q[slot[3:2]] : h_q[slot[3:2]];
      pt_byte = slot[0] ? word[7:0] : word[15:8];
      case (idx_d)
         5'd0:     byte_d = SYNC0;
         5'd1:     byte_d = SYNC1;
         5'd2:     byte_d = seq_q;
         5'd3:     byte_d = {5'd0, cnt_q};
         LAST_IDX: byte_d = csum_d;
         default:  byte_d = pt_byte;
      endcase
   end

   // VS edge detect. The trigger is delayed one cycle so the finder's outputs
   // have settled before they are sampled.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         vs_d_q   <= 1'b0;
         fall_d_q <= 1'b0;
      end else begin
         vs_d_q   <= VGA_VS;
         fall_d_q <= fall;
      end
   end

   // Packet FSM: snapshot on trigger, then step through bytes on each handshake.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= IDLE;
         h_q        <= '0;
         v_q        <= '0;
         cnt_q      <= '0;
         seq_q      <= '0;
         csum_q     <= '0;
         idx_q      <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         frame_q    <= '0;
         drop_q     <= '0;
      end else begin
         if (fall_d_q) begin
            frame_q <= frame_q + 8'd1;
            if (state_q == IDLE) begin
               h_q   <= {i_POINTS_H_3, i_POINTS_H_2, i_POINTS_H_1, i_POINTS_H_0};
               v_q   <= {i_POINTS_V_3, i_POINTS_V_2, i_POINTS_V_1, i_POINTS_V_0};
               cnt_q <= cnt_clamp;
               seq_q <= frame_q;
               if (start_ok) begin
                  state_q    <= SEND;
                  idx_q      <= 5'd0;
                  csum_q     <= 8'd0;
                  tx_data_q  <= SYNC0;
                  tx_valid_q <= 1'b1;
               end
            end else if (drop_q != 8'hFF) begin
               drop_q <= drop_q + 8'd1;
            end
         end
         if ((state_q == SEND) && xfer) begin
            if (idx_q == LAST_IDX) begin
               state_q    <= IDLE;
               idx_q      <= 5'd0;
               tx_valid_q <= 1'b0;
               tx_data_q  <= 8'd0;
            end else begin
               idx_q     <= idx_d;
               tx_data_q <= byte_d;
               csum_q    <= csum_d;
            end
         end
      end
   end

endmodule

// File: tb/tb_points_packetizer.sv
// Directed bench for points_packetizer: packet contents, backpressure,
// drop and frame counting, count clamping, mid-packet reset and empty frames.
module tb_points_packetizer;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        VGA_VS = 1'b0;
   logic [15:0] ph [4];
   logic [15:0] pv [4];
   logic [2:0]  cnt_in = 3'd0;
   logic [7:0]  o_TX_DATA;
   logic        o_TX_VALID;
   logic        TX_READY = 1'b0;
   logic        o_BUSY;
   logic [7:0]  o_FRAME_CNT, o_DROP_CNT;

   int checks = 0;
   int errors = 0;
   logic [7:0] pat = 8'b1001_1010;
   logic [7:0] pk [21];

   points_packetizer dut (
      .CLK(CLK), .RESET_N(RESET_N), .VGA_VS(VGA_VS),
      .i_POINTS_H_0(ph[0]), .i_POINTS_H_1(ph[1]), .i_POINTS_H_2(ph[2]), .i_POINTS_H_3(ph[3]),
      .i_POINTS_V_0(pv[0]), .i_POINTS_V_1(pv[1]), .i_POINTS_V_2(pv[2]), .i_POINTS_V_3(pv[3]),
      .i_POINT_COUNT(cnt_in),
      .o_TX_DATA(o_TX_DATA), .o_TX_VALID(o_TX_VALID), .i_TX_READY(TX_READY),
      .o_BUSY(o_BUSY), .o_FRAME_CNT(o_FRAME_CNT), .o_DROP_CNT(o_DROP_CNT)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET_N = 1'b0;
      repeat (2) @(negedge CLK);
      RESET_N = 1'b1;
   endtask

   task automatic vs_fall();
      @(negedge CLK);
      VGA_VS = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      VGA_VS = 1'b0;
   endtask

   task automatic set_pts(input logic [15:0] h, input logic [15:0] v);
      for (int p = 0; p < 4; p++) begin
         ph[p] = h;
         pv[p] = v;
      end
   endtask

   // Expected packet from the current bench inputs.
   task automatic build(input logic [7:0] seq, input logic [2:0] c, output logic [7:0] q [21]);
      logic [7:0] s;
      q[0] = 8'hAA; q[1] = 8'h55; q[2] = seq; q[3] = {5'd0, c};
      for (int p = 0; p < 4; p++) begin
         q[4+4*p] = ph[p][15:8]; q[5+4*p] = ph[p][7:0];
         q[6+4*p] = pv[p][15:8]; q[7+4*p] = pv[p][7:0];
      end
      s = 8'd0;
      for (int i = 2; i < 20; i++) s = s + q[i];
      q[20] = s;
   endtask

   // Accept nbytes bytes, checking each one against q. rnd applies a
   // backpressure pattern, and data is checked to be held while stalled.
   task automatic recv(input logic [7:0] q [21], input int nbytes, input bit rnd, input string tag);
      int n = 0;
      int cyc = 0;
      bit hold = 1'b0;
      logic [7:0] held = 8'd0;
      while (n < nbytes && cyc < 500) begin
         @(negedge CLK);
         cyc++;
         if (hold) chk({tag, "_hold_valid"}, o_TX_VALID, 1'b1);
         if (o_TX_VALID) begin
            if (hold) chk({tag, "_stable"}, o_TX_DATA, held);
            TX_READY = rnd ? pat[cyc % 8] : 1'b1;
            if (TX_READY) begin
               chk($sformatf("%s_b%0d", tag, n), o_TX_DATA, q[n]);
               n++;
               hold = 1'b0;
            end else begin
               hold = 1'b1;
               held = o_TX_DATA;
            end
         end
      end
      if (n < nbytes) chk({tag, "_timeout"}, n, nbytes);
   endtask

   task automatic end_pkt(input string tag, input logic [7:0] fexp, input logic [7:0] dexp);
      @(posedge CLK);
      #1;
      chk({tag, "_busy_end"}, o_BUSY, 1'b0);
      chk({tag, "_valid_end"}, o_TX_VALID, 1'b0);
      chk({tag, "_frame"}, o_FRAME_CNT, fexp);
      chk({tag, "_drop"}, o_DROP_CNT, dexp);
      TX_READY = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      set_pts(16'h0, 16'h0);
      // reset state
      #12;
      chk("rst_data", o_TX_DATA, 8'h00);
      chk("rst_valid", o_TX_VALID, 1'b0);
      chk("rst_busy", o_BUSY, 1'b0);
      chk("rst_frame", o_FRAME_CNT, 8'h00);
      chk("rst_drop", o_DROP_CNT, 8'h00);

      // 1: single point, ready held high
      do_reset();
      ph[0] = 16'h0140; pv[0] = 16'h00F0; cnt_in = 3'd1;
      build(8'h00, 3'd1, pk);
      pk[20] = 8'h32;
      vs_fall();
      @(negedge CLK); chk("t1_lat_lo", o_TX_VALID, 1'b0);
      @(negedge CLK); chk("t1_lat_hi", o_TX_VALID, 1'b1);
      recv(pk, 21, 1'b0, "t1");
      end_pkt("t1", 8'd1, 8'd0);

      // 2: same frame under backpressure
      do_reset();
      vs_fall();
      recv(pk, 21, 1'b1, "t2");
      end_pkt("t2", 8'd1, 8'd0);

      // 3: a second frame while stalled is dropped; the snapshot holds
      do_reset();
      TX_READY = 1'b0;
      vs_fall();
      repeat (3) @(negedge CLK);
      chk("t3_valid", o_TX_VALID, 1'b1);
      chk("t3_busy", o_BUSY, 1'b1);
      ph[0] = 16'h1234; pv[1] = 16'hBEEF; cnt_in = 3'd3;
      vs_fall();
      repeat (3) @(negedge CLK);
      chk("t3_drop1", o_DROP_CNT, 8'd1);
      chk("t3_frame2", o_FRAME_CNT, 8'd2);
      chk("t3_sync_held", o_TX_DATA, 8'hAA);
      recv(pk, 21, 1'b0, "t3");
      end_pkt("t3", 8'd2, 8'd1);

      // 4: count 7 is clamped to 4, all coordinates are 0xFFFF, seq=2
      set_pts(16'hFFFF, 16'hFFFF); cnt_in = 3'd7;
      build(8'h02, 3'd4, pk);
      pk[3] = 8'h04; pk[20] = 8'hF6;
      vs_fall();
      recv(pk, 21, 1'b0, "t4");
      end_pkt("t4", 8'd3, 8'd1);

      // 5: reset at byte index 10 abandons the packet
      do_reset();
      set_pts(16'h0, 16'h0);
      ph[0] = 16'h0140; pv[0] = 16'h00F0; ph[2] = 16'h0A0B; cnt_in = 3'd2;
      build(8'h00, 3'd2, pk);
      vs_fall();
      recv(pk, 10, 1'b0, "t5a");
      @(posedge CLK);
      #1;
      TX_READY = 1'b0;
      chk("t5_idx10", o_TX_DATA, pk[10]);
      #2;
      RESET_N = 1'b0;
      #1;
      chk("t5_valid_async", o_TX_VALID, 1'b0);
      chk("t5_busy", o_BUSY, 1'b0);
      chk("t5_frame", o_FRAME_CNT, 8'd0);
      chk("t5_drop", o_DROP_CNT, 8'd0);
      @(negedge CLK);
      RESET_N = 1'b1;
      vs_fall();
      recv(pk, 21, 1'b0, "t5b");
      end_pkt("t5b", 8'd1, 8'd0);

      // 6: empty frame
      do_reset();
      set_pts(16'h0, 16'h0); cnt_in = 3'd0;
`ifdef POINTS_PACKETIZER_SKIP_EMPTY_EN
      vs_fall();
      begin
         logic seen;
         seen = 1'b0;
         repeat (8) begin
            @(negedge CLK);
            seen = seen | o_TX_VALID;
         end
         chk("t6_no_valid", seen, 1'b0);
      end
      chk("t6_frame", o_FRAME_CNT, 8'd1);
      chk("t6_drop", o_DROP_CNT, 8'd0);
      chk("t6_busy", o_BUSY, 1'b0);
`else
      build(8'h00, 3'd0, pk);
      pk[20] = 8'h00;
      vs_fall();
      recv(pk, 21, 1'b0, "t6");
      end_pkt("t6", 8'd1, 8'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
